// File: rtl/arith_seq_pkg.sv
// Shared constants and types for the registered add/sub/compare/multiply unit.
package arith_seq_pkg;

  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_SUB     = 3'd1;
  localparam logic [2:0] OP_MAX     = 3'd2;
  localparam logic [2:0] OP_MUL     = 3'd3;
  localparam logic [2:0] OP_ACC_ADD = 3'd4;
  localparam logic [2:0] OP_ACC_CLR = 3'd5;

  localparam int FLG_OVF = 0;
  localparam int FLG_BRW = 1;
  localparam int FLG_GT  = 2;
  localparam int FLG_ILL = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/arith_seq_unit_if.sv
// Operand/opcode request channel and result channel, each a valid/ready pair.
interface arith_seq_unit_if #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 5
) ();

  localparam int RES_W = WIDTH_A + WIDTH_B;

  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [WIDTH_A-1:0] in_a;
  logic [WIDTH_B-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [RES_W-1:0]   out_data;
  logic [3:0]         out_flags;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );

endinterface

// File: rtl/arith_seq_mul.sv
// Shift-add multiplier: one multiplier bit per cycle, WIDTH_B cycles per product.
// done and product are combinational during the last iteration so the caller
// can register the finished product on that same edge.
module arith_seq_mul
  import arith_seq_pkg::*;
#(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [WIDTH_A-1:0]         a,
  input  logic [WIDTH_B-1:0]         b,
  output logic                       done,
  output logic [WIDTH_A+WIDTH_B-1:0] product
);

  localparam int RES_W = WIDTH_A + WIDTH_B;
  localparam int CNT_W = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_B - 1);

  logic [RES_W-1:0]   mcand;
  logic [WIDTH_B-1:0] mplier;
  logic [RES_W-1:0]   partial;
  logic [RES_W-1:0]   addend;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  // Shifted multiplicand contributes only when the current multiplier bit is set.
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    product = partial + addend;
    done    = busy && (cnt == LAST);
  end

  // Load operands on start, then iterate one multiplier bit per cycle until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      mcand   <= {{WIDTH_B{1'b0}}, a};
      mplier  <= b;
      partial <= '0;
      cnt     <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      partial <= product;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      cnt     <= cnt + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// Registered arithmetic unit: single-cycle ADD/SUB/MAX/ACC ops, multi-cycle MUL,
// running accumulator and a back-pressurable result register.
module arith_seq_unit
  import arith_seq_pkg::*;
#(
  parameter int WIDTH_A  = 4,
  parameter int WIDTH_B  = 5,
  parameter int SATURATE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  arith_seq_unit_if.slave bus
);

  localparam int RES_W = WIDTH_A + WIDTH_B;

  state_t           state;
  state_t           state_next;
  logic             in_ready_int;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [RES_W-1:0] mul_product;

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;
  logic [RES_W:0]   acc_sum;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] acc_next;
  logic [RES_W-1:0] res_next;
  logic [3:0]       flg_next;

  logic             out_valid_q;
  logic [RES_W-1:0] out_data_q;
  logic [3:0]       out_flags_q;

  assign a_ext   = {{WIDTH_B{1'b0}}, bus.in_a};
  assign b_ext   = {{WIDTH_A{1'b0}}, bus.in_b};
  assign acc_sum = {1'b0, acc} + {1'b0, a_ext};

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  arith_seq_mul #(
    .WIDTH_A(WIDTH_A),
    .WIDTH_B(WIDTH_B)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mul_start),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .done   (mul_done),
    .product(mul_product)
  );

  // State register: reset aborts any multiply in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: enter MUL_RUN on an accepted MUL, leave when the iterator finishes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL_RUN;
      MUL_RUN: if (mul_done)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: accept only when idle and the result slot is free or draining now.
  always_comb begin
    in_ready_int = (state == IDLE) && (!out_valid_q || bus.out_ready);
    accept       = bus.in_valid && in_ready_int;
    mul_start    = accept && (bus.in_op == OP_MUL);
  end

  // Single-cycle datapath: result, flags and accumulator update for the presented op.
  always_comb begin
    res_next = '0;
    flg_next = '0;
    acc_next = acc;
    case (bus.in_op)
      OP_ADD: begin
        res_next = a_ext + b_ext;
      end
      OP_SUB: begin
        flg_next[FLG_BRW] = (a_ext < b_ext);
        if ((SATURATE != 0) && (a_ext < b_ext)) begin
          res_next = '0;
        end else begin
          res_next = a_ext - b_ext;
        end
      end
      OP_MAX: begin
        flg_next[FLG_GT] = (a_ext > b_ext);
        res_next = (a_ext >= b_ext) ? a_ext : b_ext;
      end
      OP_MUL: begin
        res_next = '0;
      end
      OP_ACC_ADD: begin
        flg_next[FLG_OVF] = acc_sum[RES_W];
        if ((SATURATE != 0) && acc_sum[RES_W]) begin
          acc_next = '1;
        end else begin
          acc_next = acc_sum[RES_W-1:0];
        end
        res_next = acc_next;
      end
      OP_ACC_CLR: begin
        acc_next = '0;
        res_next = '0;
      end
      default: begin
        flg_next[FLG_ILL] = 1'b1;
      end
    endcase
  end

  // Accumulator only moves on an accepted op; MUL and illegal ops leave it as is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      acc <= acc_next;
    end
  end

  // Result register: load a new result, otherwise hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (accept && (bus.in_op != OP_MUL)) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_next;
      out_flags_q <= flg_next;
    end else if ((state == MUL_RUN) && mul_done) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mul_product;
      out_flags_q <= '0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed bench: a wrapping and a saturating instance driven in lockstep.
module tb_arith_seq_unit;
  import arith_seq_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   errors  = 0;

  arith_seq_unit_if #(.WIDTH_A(4), .WIDTH_B(5)) bus0 ();
  arith_seq_unit_if #(.WIDTH_A(4), .WIDTH_B(5)) bus1 ();

  arith_seq_unit #(.WIDTH_A(4), .WIDTH_B(5), .SATURATE(0)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  arith_seq_unit #(.WIDTH_A(4), .WIDTH_B(5), .SATURATE(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [4:0] b);
    bus0.in_valid = 1'b1; bus0.in_op = op; bus0.in_a = a; bus0.in_b = b;
    bus1.in_valid = 1'b1; bus1.in_op = op; bus1.in_a = a; bus1.in_b = b;
  endtask

  task automatic drop();
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
  endtask

  task automatic set_out_ready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Present an op at a falling edge, confirm it will be taken, step past the accept edge.
  task automatic apply_stimulus(input string tag, input logic [2:0] op,
                                input logic [3:0] a, input logic [4:0] b);
    drive(op, a, b);
    #1;
    check_output({tag, "_rdy"}, {31'd0, bus0.in_ready & bus1.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_result(input string tag, input int d0, input int d1,
                              input int f0, input int f1);
    check_output({tag, "_vld"}, {30'd0, bus1.out_valid, bus0.out_valid}, 32'd3);
    check_output({tag, "_dat0"}, {23'd0, bus0.out_data}, d0);
    check_output({tag, "_dat1"}, {23'd0, bus1.out_data}, d1);
    check_output({tag, "_flg0"}, {28'd0, bus0.out_flags}, f0);
    check_output({tag, "_flg1"}, {28'd0, bus1.out_flags}, f1);
  endtask

  task automatic check_idle_out(input string tag);
    check_output(tag, {30'd0, bus1.out_valid, bus0.out_valid}, 32'd0);
  endtask

  initial begin
    int b2b_a [4] = '{1, 7, 15, 10};
    int b2b_b [4] = '{2, 8, 0, 20};
    int b2b_r [4] = '{3, 15, 15, 30};
    logic [8:0] held;

    rst_n = 1'b0;
    drop();
    drive(3'd0, 4'd0, 5'd0);
    drop();
    set_out_ready(1'b1);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_idle_out("rst_vld");
    check_output("rst_dat", {14'd0, bus1.out_data, bus0.out_data}, 32'd0);
    check_output("rst_flg", {24'd0, bus1.out_flags, bus0.out_flags}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_output("rst_rdy", {30'd0, bus1.in_ready, bus0.in_ready}, 32'd3);
    @(negedge clk);

    // ADD with single-cycle latency, then release
    apply_stimulus("add", OP_ADD, 4'd15, 5'd31);
    drop();
    check_result("add", 46, 46, 0, 0);
    @(negedge clk);
    check_idle_out("add_rel");

    // Back-to-back ADDs: a fresh result every cycle
    for (int i = 0; i < 4; i++) begin
      apply_stimulus("b2b", OP_ADD, 4'(b2b_a[i]), 5'(b2b_b[i]));
      check_result("b2b", b2b_r[i], b2b_r[i], 0, 0);
    end
    drop();
    @(negedge clk);
    check_idle_out("b2b_rel");

    // SUB underflow: wrap vs clamp; then a plain SUB
    apply_stimulus("sub", OP_SUB, 4'd3, 5'd7);
    check_result("sub", 508, 0, 4'b0010, 4'b0010);
    apply_stimulus("sub2", OP_SUB, 4'd9, 5'd4);
    check_result("sub2", 5, 5, 0, 0);

    // MAX: a larger, b larger, equal
    apply_stimulus("max1", OP_MAX, 4'd12, 5'd5);
    check_result("max1", 12, 12, 4'b0100, 4'b0100);
    apply_stimulus("max2", OP_MAX, 4'd9, 5'd20);
    check_result("max2", 20, 20, 0, 0);
    apply_stimulus("max3", OP_MAX, 4'd7, 5'd7);
    check_result("max3", 7, 7, 0, 0);
    drop();
    @(negedge clk);

    // MUL: busy for five cycles, result in the sixth, then held under back-pressure
    apply_stimulus("mul", OP_MUL, 4'd15, 5'd31);
    drop();
    set_out_ready(1'b0);
    for (int c = 1; c <= 5; c++) begin
      check_output("mul_busy_rdy", {30'd0, bus1.in_ready, bus0.in_ready}, 32'd0);
      check_idle_out("mul_busy_vld");
      @(negedge clk);
    end
    check_result("mul", 465, 465, 0, 0);
    held = bus0.out_data;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_result("mul_hold", 465, 465, 0, 0);
      check_output("mul_hold_dat", {23'd0, bus0.out_data}, {23'd0, held});
      check_output("mul_hold_rdy", {30'd0, bus1.in_ready, bus0.in_ready}, 32'd0);
    end
    set_out_ready(1'b1);
    #1;
    check_output("mul_drain_rdy", {30'd0, bus1.in_ready, bus0.in_ready}, 32'd3);
    @(negedge clk);
    check_idle_out("mul_rel");

    // Accumulator: clear, 34 adds of 15, then overflow
    apply_stimulus("aclr", OP_ACC_CLR, 4'd9, 5'd9);
    check_result("aclr", 0, 0, 0, 0);
    for (int i = 1; i <= 34; i++) begin
      apply_stimulus("acc", OP_ACC_ADD, 4'd15, 5'd0);
    end
    check_result("acc34", 510, 510, 0, 0);
    apply_stimulus("acc35", OP_ACC_ADD, 4'd15, 5'd0);
    check_result("acc35", 13, 511, 4'b0001, 4'b0001);
    apply_stimulus("acc36", OP_ACC_ADD, 4'd15, 5'd0);
    check_result("acc36", 28, 511, 0, 4'b0001);
    drop();
    @(negedge clk);

    // Reset in the third MUL_RUN cycle aborts the multiply
    apply_stimulus("mrst", OP_MUL, 4'd15, 5'd31);
    drop();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_out("mrst_vld");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("mrst_rdy", {30'd0, bus1.in_ready, bus0.in_ready}, 32'd3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_idle_out("mrst_stale");
    end
    apply_stimulus("mrst_add", OP_ADD, 4'd1, 5'd1);
    check_result("mrst_add", 2, 2, 0, 0);

    // Illegal opcodes leave the accumulator alone
    apply_stimulus("ill_pre", OP_ACC_ADD, 4'd5, 5'd0);
    check_result("ill_pre", 5, 5, 0, 0);
    apply_stimulus("ill7", 3'd7, 4'd3, 5'd3);
    check_result("ill7", 0, 0, 4'b1000, 4'b1000);
    apply_stimulus("ill6", 3'd6, 4'd2, 5'd9);
    check_result("ill6", 0, 0, 4'b1000, 4'b1000);
    apply_stimulus("ill_post", OP_ACC_ADD, 4'd0, 5'd0);
    check_result("ill_post", 5, 5, 0, 0);
    drop();
    @(negedge clk);
    check_idle_out("end_rel");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
